stream_demux: RTL
=================

# stream_demux

Sequential 1-to-N demultiplexer/deserializer: accepts a stream of `DATAWIDTH`-bit words over a valid/ready handshake and steers each accepted word into the next lane of an `N_OUTPUTS`-wide output array. It presents the completed array as one vector with its own valid/ready handshake. It is the inverse of the N-to-1 selection mux and sits where a serial operand stream must be spread across the rows or columns of the systolic array.

## Interface
Parameters:
- `DATAWIDTH`, 16: bit width of each data word and each output lane.
- `N_OUTPUTS`, 8: number of output lanes (≥1).
- `SELWIDTH`, 3: lane-index width. Must satisfy 2^SELWIDTH ≥ N_OUTPUTS.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_data`  input  DATAWIDTH  incoming word.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block accepts `in_data` this cycle.
- `in_last`  input  1  accepted word closes the current vector early (see Configuration).
- `out_array`  output  DATAWIDTH × [N_OUTPUTS-1:0]  assembled vector; lane i holds the i-th accepted word.
- `out_count`  output  SELWIDTH+1  number of lanes filled in the presented vector.
- `out_valid`  output  1  `out_array`/`out_count` are valid.
- `out_ready`  input  1  consumer takes the vector this cycle.

## Operation
- Registers: lane registers `out_array`, lane index `idx` (SELWIDTH bits), state.
- State FILL:
  - `in_ready`=1, `out_valid`=0.
  - Accept on `in_valid`&&`in_ready`: lane[`idx`] ← `in_data`, `idx` ← `idx`+1.
  - If the accepted word has `idx`==N_OUTPUTS-1, or is closed by `in_last` (macro defined): go to HOLD, `out_count` ← `idx`+1, `idx` ← 0.
- State HOLD:
  - `out_valid`=1. `out_array`/`out_count` are stable until taken.
  - `in_ready` = `out_ready` (combinational pass-through).
  - `out_ready`=0: hold everything. `in_data` is not absorbed.
  - `out_ready`=1 and `in_valid`=0: all lanes ← 0, `out_count` ← 0, go to FILL.
  - `out_ready`=1 and `in_valid`=1: the vector is taken and the new word is accepted into lane 0 the same cycle. Lanes 1..N-1 ← 0, `idx` ← 1, go to FILL. With N_OUTPUTS=1 (or `in_last` with the macro defined), it stays in HOLD with `out_count`=1.
- Unfilled lanes of a vector always read 0.
- `in_last` on a non-accepted cycle has no effect.
- `in_last` on the word that fills lane N-1 is equivalent to a normal completion.

## Timing
- Reset (async assert, sync release):
  - Outputs: `out_array` all 0, `out_count`=0, `out_valid`=0, `in_ready`=1.
  - Internal: state FILL, `idx`=0.
- Latency: `out_valid` rises on the edge that accepts the closing word (1 cycle after that word is presented with `in_valid`).
- Throughput: one word per cycle sustained when `out_ready` is held 1. There is no bubble between vectors.
- Handshake:
  - `in_valid` must not depend on `in_ready`.
  - `out_valid`, once high, stays high until `out_ready` is sampled 1.
- Reset mid-operation discards any partial or held vector. The next vector starts at lane 0.

## Configuration
- `STREAM_DEMUX_LAST_EN` defined: `in_last` closes a partial vector; `out_count` reports the filled lanes (1..N_OUTPUTS).
- `STREAM_DEMUX_LAST_EN` undefined:
  - `in_last` is ignored; vectors close only when full.
  - `out_count` always reads N_OUTPUTS when `out_valid`=1, and 0 otherwise.

## Test plan
- Reset: hold `rst_n`=0 mid-stream → `out_valid`=0, `in_ready`=1, all lanes 0, `out_count`=0 immediately. The first word after release lands in lane 0.
- Full vector: 8 words 0x0001..0x0008, `out_ready`=1 → `out_valid` high after the 8th accept; `out_array[i]`=i+1, `out_count`=8 for exactly one cycle.
- Backpressure: `out_ready`=0 for 5 cycles after completion while `in_data` changes → `in_ready`=0, vector unchanged. On `out_ready`=1 the waiting word goes into lane 0.
- Back-to-back: 16 words 0x0010..0x001F over 16 consecutive cycles, `out_ready`=1 → two vectors: 0x0010..0x0017, then 0x0018..0x001F. No `in_ready` deassertion.
- Early close, macro defined: 3 words 0xA,0xB,0xC with `in_last` on 0xC → `out_count`=3, lanes 0–2 = 0xA,0xB,0xC, lanes 3–7 = 0.
- Early close, macro undefined: same stimulus → no `out_valid`; completes only after 5 more words, with `out_count`=8.

Source files
------------

// File: rtl/stream_demux_if.sv
// stream_demux_if: serial word input and assembled vector output of the
// stream demultiplexer. The slave side is the demux; the master side is the
// producer/consumer pair around it.
interface stream_demux_if #(
  parameter int DATAWIDTH = 16,
  parameter int N_OUTPUTS = 8,
  parameter int SELWIDTH  = 3
);
  logic [DATAWIDTH-1:0]                in_data;
  logic                                in_valid;
  logic                                in_ready;
  logic                                in_last;
  logic [N_OUTPUTS-1:0][DATAWIDTH-1:0] out_array;
  logic [SELWIDTH:0]                   out_count;
  logic                                out_valid;
  logic                                out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_array, out_count, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_array, out_count, out_valid
  );
endinterface

// File: rtl/stream_demux.sv
// stream_demux: 1-to-N deserializer. Accepted words fill lanes 0..N-1 in
// order; the completed vector is held with out_valid until taken. While a
// vector is held, in_ready follows out_ready so the next vector's first word
// can be accepted in the same cycle the held one is taken (no bubble).
// Optional feature: define STREAM_DEMUX_LAST_EN to let in_last close a
// partial vector early; otherwise in_last is ignored.

// One output lane: loads on its write strobe, clears when the vector is taken.
// A load wins over the clear so lane 0 can take a new word on the take cycle.
module stream_demux_lane #(
  parameter int DATAWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 clr,
  input  logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] q
);
  // lane storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (wr_en) q <= d;
    else if (clr)   q <= '0;
  end
endmodule

module stream_demux #(
  parameter int DATAWIDTH = 16,
  parameter int N_OUTPUTS = 8,
  parameter int SELWIDTH  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  stream_demux_if.slave bus
);
  localparam int CW = SELWIDTH + 1;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                              state, state_nxt;
  logic [SELWIDTH-1:0]                 idx, wr_idx;
  logic [CW-1:0]                       count;
  logic                                in_rdy, acc, take, close, last_close;
  logic [N_OUTPUTS-1:0]                wr_en;
  logic [N_OUTPUTS-1:0][DATAWIDTH-1:0] lanes;

`ifdef STREAM_DEMUX_LAST_EN
  assign last_close = bus.in_last;
`else
  logic unused_last;
  assign last_close  = 1'b0;
  assign unused_last = bus.in_last;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // next state: a closing accept always lands in HOLD (also from HOLD when
  // the new word closes a one-lane vector); a take without close goes to FILL
  always_comb begin
    state_nxt = state;
    if (close)     state_nxt = HOLD;
    else if (take) state_nxt = FILL;
  end

  // handshake outputs and datapath strobes; in HOLD the write target is lane 0
  always_comb begin
    in_rdy        = (state == FILL) || bus.out_ready;
    bus.in_ready  = in_rdy;
    bus.out_valid = (state == HOLD);
    take          = (state == HOLD) && bus.out_ready;
    acc           = bus.in_valid && in_rdy;
    wr_idx        = (state == FILL) ? idx : '0;
    close         = acc && ((wr_idx == SELWIDTH'(N_OUTPUTS - 1)) || last_close);
  end

  // lane index and filled-lane count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      count <= '0;
    end else begin
      if (close)    idx <= '0;
      else if (acc) idx <= wr_idx + SELWIDTH'(1);
      if (close)     count <= CW'(wr_idx) + CW'(1);
      else if (take) count <= '0;
    end
  end

  for (genvar i = 0; i < N_OUTPUTS; i++) begin : g_lane
    assign wr_en[i] = acc && (wr_idx == SELWIDTH'(i));
    stream_demux_lane #(.DATAWIDTH(DATAWIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_en[i]),
      .clr   (take),
      .d     (bus.in_data),
      .q     (lanes[i])
    );
  end

  assign bus.out_array = lanes;
  assign bus.out_count = count;
endmodule
